// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and glyph constants for the 7-segment scan driver.
// Producers of raw-mode text reuse the GLYPH_* patterns directly.
package seg7_scan_driver_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } upd_state_e;

    // Bit positions inside an active-low {dp,g,f,e,d,c,b,a} segment byte
    typedef enum int {
        SEG_A  = 0,
        SEG_B  = 1,
        SEG_C  = 2,
        SEG_D  = 3,
        SEG_E  = 4,
        SEG_F  = 5,
        SEG_G  = 6,
        SEG_DP = 7
    } seg_bit_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;

    // Letters for score/text banners; O shares the zero shape, R is lowercase r
    localparam logic [7:0] GLYPH_S = 8'h92;
    localparam logic [7:0] GLYPH_O = 8'hC0;
    localparam logic [7:0] GLYPH_R = 8'hAF;

endpackage

// File: rtl/seg7_hex_nibble.sv
// Combinational hex nibble to active-low gfedcba pattern.
module seg7_hex_nibble
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // NOTE: default assigned first so every path drives o_seg and no latch is inferred.
    always_comb begin
        o_seg = SEG_OFF[6:0];
        case (i_nibble)
            4'h0: o_seg = GLYPH_0[6:0];
            4'h1: o_seg = GLYPH_1[6:0];
            4'h2: o_seg = GLYPH_2[6:0];
            4'h3: o_seg = GLYPH_3[6:0];
            4'h4: o_seg = GLYPH_4[6:0];
            4'h5: o_seg = GLYPH_5[6:0];
            4'h6: o_seg = GLYPH_6[6:0];
            4'h7: o_seg = GLYPH_7[6:0];
            4'h8: o_seg = GLYPH_8[6:0];
            4'h9: o_seg = GLYPH_9[6:0];
            4'hA: o_seg = GLYPH_A[6:0];
            4'hB: o_seg = GLYPH_B[6:0];
            4'hC: o_seg = GLYPH_C[6:0];
            4'hD: o_seg = GLYPH_D[6:0];
            4'hE: o_seg = GLYPH_E[6:0];
            4'hF: o_seg = GLYPH_F[6:0];
            default: o_seg = SEG_OFF[6:0];
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with
// frame-synchronous snapshot commit, blanking, blink and zero suppression.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD     = 1,
    parameter int BLINK_BIT = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    output logic                  ready,
    input  logic                  raw_mode,
    input  logic                  lzs,
    input  logic [4*DIGITS-1:0]   hex,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     blink,
    input  logic [8*DIGITS-1:0]   raw,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef struct packed {
        logic                raw_mode;
        logic                lzs;
        logic [4*DIGITS-1:0] hex;
        logic [DIGITS-1:0]   point;
        logic [DIGITS-1:0]   blank;
        logic [DIGITS-1:0]   blink;
        logic [8*DIGITS-1:0] raw;
    } snap_t;

    localparam snap_t SNAP_RESET = '{
        raw_mode: 1'b0, lzs: 1'b0, hex: '0, point: '0,
        blank: '1, blink: '0, raw: '1
    };

    logic [PW-1:0]      r_pcnt;
    logic [IW-1:0]      r_idx;
    logic [BLINK_BIT:0] r_fcnt;
    upd_state_e         r_state;
    upd_state_e         w_state_nxt;
    snap_t              r_shadow;
    snap_t              r_active;
    snap_t              w_snap_in;
    logic               w_tick;
    logic               w_last;
    logic               w_frame_end;
    logic               w_capture;
    logic               w_commit;

    assign w_tick      = (r_pcnt == PW'(SCAN_DIV - 1));
    assign w_last      = (r_idx == IW'(DIGITS - 1));
    assign w_frame_end = w_tick & w_last;
    assign ready       = (r_state == ST_IDLE);

    assign w_snap_in = '{
        raw_mode: raw_mode, lzs: lzs, hex: hex, point: point,
        blank: blank, blink: blink, raw: raw
    };

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
            r_idx  <= '0;
            r_fcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
            r_idx  <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) r_fcnt <= r_fcnt + 1'b1;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A load arriving while an update is pending is dropped, not queued
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: if (load) begin
                w_capture   = 1'b1;
                w_state_nxt = ST_PEND;
            end
            ST_PEND: if (w_frame_end) begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= SNAP_RESET;
            r_active <= SNAP_RESET;
        end else begin
            if (w_capture) r_shadow <= w_snap_in;
            if (w_commit)  r_active <= r_shadow;
        end
    end

    logic [3:0] w_hex_d [DIGITS];
    logic [7:0] w_raw_d [DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_unpack
        assign w_hex_d[g] = r_active.hex[4*g +: 4];
        assign w_raw_d[g] = r_active.raw[8*g +: 8];
    end

    // Top-down prefix-OR: a digit is a leading zero when it and all above are zero
    logic [DIGITS-1:0] w_lz_mask;
    always_comb begin
        logic v_any_nz;
        v_any_nz  = 1'b0;
        w_lz_mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_any_nz     = v_any_nz | (|w_hex_d[i]);
            w_lz_mask[i] = ~v_any_nz;
        end
    end

    logic [6:0] w_glyph;

    seg7_hex_nibble u_hex_nibble (
        .i_nibble (w_hex_d[r_idx]),
        .o_seg    (w_glyph)
    );

    logic       w_dark;
    logic [7:0] w_seg_lit;

    always_comb begin
        w_dark = r_active.blank[r_idx]
               | (r_active.blink[r_idx] & r_fcnt[BLINK_BIT])
               | (~r_active.raw_mode & r_active.lzs & (r_idx != '0) & w_lz_mask[r_idx]);
        if (r_active.raw_mode) begin
            w_seg_lit = w_raw_d[r_idx];
        end else begin
            w_seg_lit         = {1'b1, w_glyph};
            w_seg_lit[SEG_DP] = ~r_active.point[r_idx];
        end
    end

    logic [DIGITS-1:0] r_an;
    logic [7:0]        r_seg;

    // Dark digits still get their anode slot so brightness stays uniform
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
        end else begin
            r_an  <= (int'(r_pcnt) < GUARD) ? '1 : ~(DIGITS'(1) << r_idx);
            r_seg <= w_dark ? SEG_OFF : w_seg_lit;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random
// snapshots, compared every cycle against a cycle-count reference model.
module tb_seg7_scan_driver;
    import seg7_scan_driver_pkg::*;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int GUARD     = 1;
    localparam int BLINK_BIT = 1;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    logic        clk;
    logic        rst;
    logic        load;
    logic        ready;
    logic        raw_mode;
    logic        lzs;
    logic [15:0] hex;
    logic [3:0]  point;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic [31:0] raw;
    logic [3:0]  an;
    logic [7:0]  seg;

    seg7_scan_driver #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .GUARD     (GUARD),
        .BLINK_BIT (BLINK_BIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .ready    (ready),
        .raw_mode (raw_mode),
        .lzs      (lzs),
        .hex      (hex),
        .point    (point),
        .blank    (blank),
        .blink    (blink),
        .raw      (raw),
        .an       (an),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        raw_mode;
        logic        lzs;
        logic [15:0] hex;
        logic [3:0]  point;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic [31:0] raw;
    } snap_t;

    localparam snap_t SNAP_RST = '{
        raw_mode: 1'b0, lzs: 1'b0, hex: 16'h0, point: 4'h0,
        blank: 4'hF, blink: 4'h0, raw: 32'hFFFF_FFFF
    };

    // Active-low gfedcba shapes for 0..F
    logic [6:0] hex7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int          n_tests = 0;
    int          n_fail  = 0;
    string       phase   = "init";
    int unsigned m       = 0;   // non-reset edges since the last reset
    bit          pend    = 1'b0;
    snap_t       act     = SNAP_RST;
    snap_t       shd     = SNAP_RST;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s at t=%0t: got %h, expected %h", phase, tag, $time, got, exp);
        end
    endtask

    // Expected registered outputs produced from m elapsed edges and snapshot s
    function automatic void exp_out(input int unsigned mm, input snap_t s,
                                    output logic [3:0] e_an, output logic [7:0] e_seg);
        int unsigned idx   = (mm / SCAN_DIV) % DIGITS;
        int unsigned pc    = mm % SCAN_DIV;
        int unsigned frame = mm / FRAME;
        bit dark;
        bit any_nz;
        e_an = 4'hF;
        if (pc >= GUARD) e_an[idx] = 1'b0;
        dark = s.blank[idx] || (s.blink[idx] && (((frame >> BLINK_BIT) & 1) == 1));
        if (!s.raw_mode && s.lzs && idx != 0) begin
            any_nz = 1'b0;
            for (int j = idx; j < DIGITS; j++)
                if (s.hex[4*j +: 4] != 4'h0) any_nz = 1'b1;
            if (!any_nz) dark = 1'b1;
        end
        if (dark)            e_seg = 8'hFF;
        else if (s.raw_mode) e_seg = s.raw[8*idx +: 8];
        else                 e_seg = {~s.point[idx], hex7[s.hex[4*idx +: 4]]};
    endfunction

    task automatic cycle();
        logic [3:0] e_an;
        logic [7:0] e_seg;
        snap_t      cur;
        cur = '{raw_mode: raw_mode, lzs: lzs, hex: hex, point: point,
                blank: blank, blink: blink, raw: raw};
        if (rst) begin
            e_an  = 4'hF;
            e_seg = 8'hFF;
            act   = SNAP_RST;
            shd   = SNAP_RST;
            pend  = 1'b0;
            m     = 0;
        end else begin
            exp_out(m, act, e_an, e_seg);
            if (pend) begin
                if (((m + 1) % FRAME) == 0) begin
                    act  = shd;
                    pend = 1'b0;
                end
            end else if (load) begin
                shd  = cur;
                pend = 1'b1;
            end
            m++;
        end
        @(posedge clk);
        #1;
        check("an", {28'd0, an}, {28'd0, e_an});
        check("seg", {24'd0, seg}, {24'd0, e_seg});
        check("ready", {31'd0, ready}, {31'd0, !pend});
    endtask

    task automatic drive(input snap_t s);
        raw_mode = s.raw_mode;
        lzs      = s.lzs;
        hex      = s.hex;
        point    = s.point;
        blank    = s.blank;
        blink    = s.blink;
        raw      = s.raw;
    endtask

    task automatic do_load(input snap_t s);
        drive(s);
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    function automatic snap_t hex_snap(input logic [15:0] h, input logic [3:0] p,
                                       input logic l, input logic [3:0] bl);
        hex_snap = '{raw_mode: 1'b0, lzs: l, hex: h, point: p,
                     blank: 4'h0, blink: bl, raw: 32'hFFFF_FFFF};
    endfunction

    function automatic snap_t raw_snap(input logic [31:0] r, input logic [3:0] p);
        raw_snap = '{raw_mode: 1'b1, lzs: 1'b1, hex: 16'h0, point: p,
                     blank: 4'h0, blink: 4'h0, raw: r};
    endfunction

    initial begin
        snap_t s;
        rst = 1'b1;
        load = 1'b0;
        drive(SNAP_RST);

        phase = "reset";
        repeat (2) cycle();
        rst = 1'b0;
        repeat (3 * FRAME) cycle();

        phase = "hex_dp";
        repeat (5) cycle();
        do_load(hex_snap(16'h12A0, 4'b0010, 1'b0, 4'h0));
        repeat (2 * FRAME) cycle();

        phase = "lzs";
        do_load(hex_snap(16'h0050, 4'b0000, 1'b1, 4'h0));
        repeat (2 * FRAME) cycle();
        do_load(hex_snap(16'h0000, 4'b0000, 1'b1, 4'h0));
        repeat (2 * FRAME) cycle();

        phase = "blink";
        do_load(hex_snap(16'h1234, 4'b0100, 1'b0, 4'b0001));
        repeat (9 * FRAME) cycle();

        phase = "raw";
        do_load(raw_snap({SEG_OFF, 8'h92, 8'hC6, 8'hC0}, 4'hF));
        repeat (2 * FRAME) cycle();
        do_load(raw_snap({GLYPH_S, GLYPH_C, GLYPH_O, GLYPH_R}, 4'h5));
        repeat (2 * FRAME) cycle();
        do_load(raw_snap({GLYPH_E, GLYPH_E, GLYPH_E, GLYPH_E}, 4'h0));
        repeat (2 * FRAME) cycle();

        phase = "boundary_load";
        while (((m + 1) % FRAME) != 0) cycle();
        do_load(hex_snap(16'hBEEF, 4'b1001, 1'b0, 4'h0));
        repeat (3 * FRAME) cycle();

        phase = "pend_ignore";
        repeat (7) cycle();
        do_load(hex_snap(16'h4321, 4'b0001, 1'b0, 4'h0));
        repeat (2) cycle();
        do_load(hex_snap(16'h9999, 4'b1111, 1'b0, 4'h0));
        repeat (2 * FRAME) cycle();

        phase = "rst_pend";
        repeat (3) cycle();
        do_load(hex_snap(16'h7777, 4'b0000, 1'b0, 4'h0));
        repeat (2) cycle();
        drive(hex_snap(16'h5555, 4'b1111, 1'b0, 4'h0));
        load = 1'b1;
        rst  = 1'b1;
        cycle();
        rst  = 1'b0;
        load = 1'b0;
        repeat (2 * FRAME) cycle();

        phase = "random";
        for (int k = 0; k < 40; k++) begin
            s.raw_mode = 1'($urandom);
            s.lzs      = 1'($urandom);
            s.hex      = 16'($urandom);
            if ($urandom_range(0, 2) == 0) s.hex[15:8] = 8'h00;
            s.point    = 4'($urandom);
            s.blank    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            s.blink    = 4'($urandom);
            s.raw      = $urandom;
            repeat ($urandom_range(0, 20)) cycle();
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
            do_load(s);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 6)) cycle();
                s.hex = 16'($urandom);
                do_load(s);
            end
        end
        repeat (2 * FRAME) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
